uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte FIFO between the bus-side register logic and the UART transmitter.
- Accepts bytes written by the CPU and drains them one at a time into the transmitter through its latch/busy handshake.
- The CPU can queue up to DEPTH bytes without polling the transmitter's busy bit per byte.
- Exposes level and sticky-overflow status for the status register.

Parameters:
- DEPTH, 16, FIFO capacity in bytes; must be a power of two, at least 2.
- ADDR_W, 4, log2(DEPTH); pointer width.
- BUSY_TIMEOUT, 4, maximum cycles to wait for tx_busy to rise after a latch pulse.

Ports:
- clk  input  1  system clock (16 MHz).
- rst  input  1  synchronous reset, active-high.
- wr_data  input  8  byte to enqueue.
- wr_en  input  1  single-cycle push strobe.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  ADDR_W+1  number of bytes stored.
- overflow  output  1  sticky flag: a push was dropped.
- clear_overflow  input  1  clears overflow.
- tx_data  output  8  byte presented to the transmitter.
- tx_latch  output  1  one-cycle latch strobe to the transmitter.
- tx_busy  input  1  transmitter busy; rises the cycle after an accepted latch and stays high for the whole frame.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - rst has priority over all other inputs.
  - Reset values: pointers 0, count 0, empty 1, full 0, overflow 0, tx_latch 0, tx_data 8'h00, FSM in IDLE, timeout counter 0.
- Storage:
  - Circular buffer of DEPTH x 8 bits with ADDR_W-bit read and write pointers.
  - Pointers wrap from DEPTH-1 to 0.
  - count is a separate register; full and empty are decoded from count and are combinational from registers.
- Push:
  - wr_en && !full: write wr_data at wr_ptr, increment wr_ptr.
  - wr_en && full: byte dropped, memory and pointers unchanged, overflow <= 1.
- Overflow:
  - clear_overflow clears overflow.
  - If clear_overflow and a dropped push occur in the same cycle, the set wins.
- Pop: occurs only when the FSM issues tx_latch.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: unchanged.
  - A pop is never issued when empty, because the FSM uses registered empty.
- Drain FSM states:
  - IDLE:
    - If !empty && !tx_busy: tx_data <= mem[rd_ptr], tx_latch <= 1, rd_ptr++, go to WAIT_BUSY with the timeout counter cleared.
    - Otherwise tx_latch <= 0.
  - WAIT_BUSY:
    - tx_latch <= 0; tx_data is held.
    - If tx_busy, go to WAIT_DONE.
    - Else, if the timeout counter == BUSY_TIMEOUT-1, go to IDLE (latch assumed lost; the byte is not re-sent).
    - Else increment the timeout counter.
  - WAIT_DONE:
    - Stay while tx_busy; go to IDLE when tx_busy == 0.
- Latch pulse and data hold:
  - tx_latch is exactly one cycle wide.
  - tx_data is valid in the cycle tx_latch is high and is held until the next latch.
- Latency:
  - A push at edge k into an empty FIFO with an idle transmitter gives tx_latch high in the cycle after edge k+1. That is 2 cycles from wr_en to tx_latch.
  - Back-to-back bytes: the next latch comes 1 cycle after the FSM returns to IDLE (the cycle after tx_busy falls).
- Mid-operation reset:
  - rst during WAIT_BUSY or WAIT_DONE returns the FSM to IDLE and empties the FIFO.
  - The frame already in the transmitter is not aborted.
  - The FSM issues no latch while tx_busy remains high.
- Transmitter already busy at startup: a byte in the FIFO waits in IDLE until tx_busy is low.
- Pointer MSB: none; count disambiguates full from empty.

Test Plan:
1. Reset, then one push of 8'hA5 with tx_busy tied to a model (rises 1 cycle after the latch, high for 1668 cycles):
   - tx_latch is high for one cycle, 2 cycles after wr_en, with tx_data == 8'hA5.
   - empty == 1 afterwards.
   - No second latch occurs.
2. Push 16 bytes 8'h00..8'h0F back-to-back with the model busy:
   - full == 1 once all 16 are queued.
   - A 17th push (8'hFF) is dropped and overflow == 1.
   - The latched sequence is exactly 00..0F in order; 8'hFF is never latched.
   - clear_overflow returns overflow to 0.
3. Wrap-around:
   - Push 10 bytes, drain all, then push 12 more.
   - The pointers wrap past DEPTH-1.
   - The 12 bytes come out in order and count returns to 0.
4. Simultaneous events:
   - Push in the same cycle the FSM pops, with count == 5: count stays 5.
   - clear_overflow together with a dropped push: overflow stays 1.
5. Lost latch:
   - tx_busy held 0 after a latch.
   - The FSM returns to IDLE after 4 cycles and latches the next byte.
   - The previous byte is not re-sent.
6. Reset mid-operation:
   - Assert rst in WAIT_DONE with 3 bytes queued.
   - Afterwards: count == 0, empty == 1, tx_latch == 0, overflow == 0.
   - No latch occurs until a new push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : Byte FIFO draining into a UART transmitter via latch/busy handshake
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clear_overflow,
    output logic [7:0]        tx_data,
    output logic              tx_latch,
    input  logic              tx_busy
);

    localparam int                 c_tmo_w    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [ADDR_W:0]    c_depth    = (ADDR_W+1)'(DEPTH);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    logic [7:0]         r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_overflow;
    state_t             r_state;
    logic [c_tmo_w-1:0] r_tmo;
    logic [7:0]         r_tx_data;
    logic               r_tx_latch;

    logic               w_push;
    logic               w_drop;
    logic               w_pop;

    assign full     = (r_count == c_depth);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign overflow = r_overflow;
    assign tx_data  = r_tx_data;
    assign tx_latch = r_tx_latch;

    assign w_push = wr_en && !full;
    assign w_drop = wr_en && full;
    // Pop only from IDLE on registered empty, so an empty FIFO is never read.
    assign w_pop  = (r_state == S_IDLE) && !empty && !tx_busy;

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            // A dropped push outranks a simultaneous clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tmo      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_latch <= 1'b0;
        end else begin
            r_tx_latch <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= r_mem[r_rd_ptr];
                        r_tx_latch <= 1'b1;
                        r_tmo      <= '0;
                        r_state    <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    // If busy never rises the latch is treated as lost; no resend.
                    if (tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_tmo == c_tmo_last) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + c_tmo_w'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Brief    : Self-checking bench for uart_tx_fifo with transmitter model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       clear_overflow;
    logic [7:0] tx_data;
    logic       tx_latch;
    logic       tx_busy = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .BUSY_TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .tx_data        (tx_data),
        .tx_latch       (tx_latch),
        .tx_busy        (tx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: stored bytes, overflow flag, last latched byte
    logic [7:0] m_q[$];
    logic       m_ovf  = 1'b0;
    logic [7:0] m_last = 8'h00;
    logic [7:0] lat_log[$];
    int         lat_cyc[$];
    int         cyc = 0;
    int         last_push_cyc = 0;
    logic       prev_latch = 1'b0;
    bit         accept;

    // Transmitter model controls
    int busy_len   = 10;
    int busy_left  = 0;
    bit busy_start = 0;
    bit busy_hold  = 0;
    bit lose_mode  = 0;

    logic       s_wr_en, s_clr, s_rst, s_busy;
    logic [7:0] s_wr_data;

    always @(posedge clk) begin
        s_wr_en   = wr_en;
        s_wr_data = wr_data;
        s_clr     = clear_overflow;
        s_rst     = rst;
        s_busy    = tx_busy;
        cyc++;
        #1;
        if (s_rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_last = 8'h00;
            check_eq("rst_latch", {31'd0, tx_latch}, 32'd0);
        end else begin
            accept = (m_q.size() < DEPTH);
            if (tx_latch) begin
                check_eq("latch_q_nonempty", {31'd0, tx_latch}, {31'd0, m_q.size() != 0});
                check_eq("latch_busy_low", {31'd0, s_busy}, 32'd0);
                check_eq("latch_width", {31'd0, prev_latch}, 32'd0);
                if (m_q.size() != 0) begin
                    check_eq("latch_data", {24'd0, tx_data}, {24'd0, m_q[0]});
                    m_last = m_q.pop_front();
                end
                lat_log.push_back(tx_data);
                lat_cyc.push_back(cyc);
            end
            if (s_wr_en && accept) begin
                m_q.push_back(s_wr_data);
                last_push_cyc = cyc;
            end
            if (s_wr_en && !accept) m_ovf = 1'b1;
            else if (s_clr)         m_ovf = 1'b0;
        end
        check_eq("count", {27'd0, count}, m_q.size());
        check_eq("empty", {31'd0, empty}, {31'd0, m_q.size() == 0});
        check_eq("full", {31'd0, full}, {31'd0, m_q.size() == DEPTH});
        check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (!tx_latch) check_eq("tx_data_hold", {24'd0, tx_data}, {24'd0, m_last});
        prev_latch = tx_latch;

        if (busy_start) begin
            busy_start = 0;
            busy_left  = busy_len;
        end
        if (tx_latch && !lose_mode) busy_start = 1;
        tx_busy = busy_hold || (busy_left > 0);
        if (busy_left > 0) busy_left--;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((m_q.size() != 0 || tx_busy || busy_start || busy_left != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", {31'd0, n < max_cyc}, 32'd1);
        tick(8);
    endtask

    task automatic hold_busy();
        busy_hold = 1;
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp[$];
        logic [7:0] b;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clear_overflow = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_count", {27'd0, count}, 32'd0);
        check_eq("reset_empty", {31'd0, empty}, 32'd1);
        check_eq("reset_tx_data", {24'd0, tx_data}, 32'd0);
        check_eq("reset_latch", {31'd0, tx_latch}, 32'd0);

        // 1: single byte, long frame
        busy_len = 1668;
        lat_log.delete(); lat_cyc.delete();
        push(8'hA5);
        wait_drain(2000);
        tick(20);
        check_eq("t1_latches", lat_log.size(), 32'd1);
        if (lat_log.size() > 0) begin
            check_eq("t1_data", {24'd0, lat_log[0]}, 32'hA5);
            check_eq("t1_latency", lat_cyc[0] - last_push_cyc, 32'd1);
        end
        check_eq("t1_empty", {31'd0, empty}, 32'd1);

        // 2: fill, overflow, ordered drain
        busy_len = $urandom_range(3, 30);
        lat_log.delete();
        hold_busy();
        for (int i = 0; i < 16; i++) push(8'(i));
        check_eq("t2_full", {31'd0, full}, 32'd1);
        push(8'hFF);
        check_eq("t2_overflow", {31'd0, overflow}, 32'd1);
        busy_hold = 0;
        wait_drain(1500);
        check_eq("t2_latches", lat_log.size(), 32'd16);
        for (int i = 0; i < 16 && i < lat_log.size(); i++)
            check_eq("t2_order", {24'd0, lat_log[i]}, i);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check_eq("t2_clear_ovf", {31'd0, overflow}, 32'd0);

        // 3: wrap-around with random gaps
        for (int pass = 0; pass < 2; pass++) begin
            lat_log.delete(); exp.delete();
            busy_len = $urandom_range(2, 20);
            for (int i = 0; i < (pass == 0 ? 10 : 12); i++) begin
                b = 8'($urandom);
                exp.push_back(b);
                push(b);
                tick($urandom_range(0, 3));
            end
            wait_drain(1500);
            check_eq("t3_latches", lat_log.size(), exp.size());
            for (int i = 0; i < exp.size() && i < lat_log.size(); i++)
                check_eq("t3_order", {24'd0, lat_log[i]}, {24'd0, exp[i]});
            check_eq("t3_count_zero", {27'd0, count}, 32'd0);
        end

        // 4a: push coinciding with a pop at count 5
        busy_len = 6;
        lat_log.delete();
        hold_busy();
        for (int i = 0; i < 5; i++) push(8'($urandom));
        busy_hold = 0;
        tick(1);
        push(8'h5A);
        check_eq("t4_latch_now", {31'd0, tx_latch}, 32'd1);
        check_eq("t4_count_5", {27'd0, count}, 32'd5);
        wait_drain(500);

        // 4b: clear together with a dropped push
        hold_busy();
        for (int i = 0; i < 16; i++) push(8'($urandom));
        clear_overflow = 1'b1;
        push(8'hEE);
        clear_overflow = 1'b0;
        check_eq("t4_ovf_set_wins", {31'd0, overflow}, 32'd1);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check_eq("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
        busy_hold = 0;
        wait_drain(1500);

        // 5: lost latch
        lose_mode = 1;
        lat_log.delete(); lat_cyc.delete();
        push(8'h11);
        push(8'h22);
        wait_drain(200);
        tick(10);
        check_eq("t5_latches", lat_log.size(), 32'd2);
        if (lat_log.size() == 2) begin
            check_eq("t5_first", {24'd0, lat_log[0]}, 32'h11);
            check_eq("t5_second", {24'd0, lat_log[1]}, 32'h22);
            check_eq("t5_gap", lat_cyc[1] - lat_cyc[0], 32'd5);
        end
        lose_mode = 0;

        // 6: reset while waiting for the frame to finish
        busy_len = 200;
        lat_log.delete();
        for (int i = 0; i < 4; i++) push(8'($urandom));
        tick(3);
        check_eq("t6_queued", {27'd0, count}, 32'd3);
        check_eq("t6_busy", {31'd0, tx_busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_count", {27'd0, count}, 32'd0);
        check_eq("t6_empty", {31'd0, empty}, 32'd1);
        check_eq("t6_latch", {31'd0, tx_latch}, 32'd0);
        check_eq("t6_ovf", {31'd0, overflow}, 32'd0);
        tick(250);
        check_eq("t6_no_latch", lat_log.size(), 32'd1);
        busy_len = 8;
        push(8'h3C);
        wait_drain(200);
        check_eq("t6_after_push", lat_log.size(), 32'd2);
        if (lat_log.size() == 2) check_eq("t6_data", {24'd0, lat_log[1]}, 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
